// File: rtl/nn_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : nn_pkg
//  Description : Shared constants and state encoding for the NN inference
//                front-end (pixel_stream_loader) and the NN core.
//  Revision    : 1.0 - initial release
// ============================================================================
package nn_pkg;

    localparam int N_IN         = 784;
    localparam int N_OUT        = 10;
    localparam int ADDR_W       = 10;
    localparam int PIX_W        = 8;
    localparam int PIX_PER_WORD = 4;
    localparam int WORD_W       = PIX_W * PIX_PER_WORD;

    // Loader FSM encoding (explicit 3-bit width)
    typedef logic [2:0] state_t;
    localparam state_t S_RECV   = 3'd0;
    localparam state_t S_UNPACK = 3'd1;
    localparam state_t S_DRAIN  = 3'd2;
    localparam state_t S_START  = 3'd3;
    localparam state_t S_RESULT = 3'd4;
    localparam state_t S_REARM  = 3'd5;

    // Width of a counter that must hold values 0..n-1 (at least 1 bit)
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/word_unpacker.sv
`default_nettype none
// ============================================================================
//  Module      : word_unpacker
//  Description : Latches one stream word and emits its pixels as registered
//                core writes, one lane per cycle, lowest byte first.
//  Revision    : 1.0 - initial release
// ============================================================================
module word_unpacker
    import nn_pkg::*;
#(
    parameter int ADDR_W = nn_pkg::ADDR_W,
    parameter int WC_W   = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_load,
    input  logic                i_step,
    input  logic [WORD_W-1:0]   i_word,
    input  logic [WC_W-1:0]     i_word_cnt,
    output logic                o_last_lane,
    output logic                o_pix_we,
    output logic [ADDR_W-1:0]   o_pix_addr,
    output logic [PIX_W-1:0]    o_pix_data
);

    localparam int LANE_W = cnt_width(PIX_PER_WORD);
    localparam logic [LANE_W-1:0] c_last_lane = LANE_W'(PIX_PER_WORD - 1);

    logic [WORD_W-1:0] r_word;
    logic [LANE_W-1:0] r_lane;
    logic              r_pix_we;
    logic [ADDR_W-1:0] r_pix_addr;
    logic [PIX_W-1:0]  r_pix_data;

    logic [LANE_W-1:0] w_next_lane;
    logic [ADDR_W-1:0] w_base;

    // Word base address and the lane that follows the one being written
    always_comb begin
        w_base      = ADDR_W'({i_word_cnt, {LANE_W{1'b0}}});
        w_next_lane = r_lane + LANE_W'(1);
    end

    // Load presents lane 0 immediately; each step advances one lane until the last
    always_ff @(posedge clk) begin
        if (rst) begin
            r_word     <= '0;
            r_lane     <= '0;
            r_pix_we   <= 1'b0;
            r_pix_addr <= '0;
            r_pix_data <= '0;
        end else if (i_load) begin
            r_word     <= i_word;
            r_lane     <= '0;
            r_pix_we   <= 1'b1;
            r_pix_addr <= w_base;
            r_pix_data <= i_word[PIX_W-1:0];
        end else if (i_step && !o_last_lane) begin
            r_lane     <= w_next_lane;
            r_pix_we   <= 1'b1;
            r_pix_addr <= r_pix_addr + ADDR_W'(1);
            r_pix_data <= r_word[w_next_lane*PIX_W +: PIX_W];
        end else begin
            r_pix_we   <= 1'b0;
        end
    end

    assign o_last_lane = (r_lane == c_last_lane);
    assign o_pix_we    = r_pix_we;
    assign o_pix_addr  = r_pix_addr;
    assign o_pix_data  = r_pix_data;

endmodule
`default_nettype wire

// File: rtl/pixel_stream_loader.sv
`default_nettype none
// ============================================================================
//  Module      : pixel_stream_loader
//  Description : AXI-Stream front-end for the NN core. Unpacks one frame of
//                packed pixels into core writes, runs one inference and
//                holds the class until it is consumed.
//  Revision    : 1.0 - initial release
// ============================================================================
module pixel_stream_loader
    import nn_pkg::*;
#(
    parameter int N_IN   = nn_pkg::N_IN,
    parameter int N_OUT  = nn_pkg::N_OUT,
    parameter int ADDR_W = nn_pkg::ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       s_axis_tdata,
    input  logic              s_axis_tvalid,
    output logic              s_axis_tready,
    input  logic              s_axis_tlast,
    output logic              pix_we,
    output logic [ADDR_W-1:0] pix_addr,
    output logic [7:0]        pix_data,
    output logic              core_start,
    input  logic              core_done,
    input  logic [3:0]        core_predicted,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [3:0]        res_class,
    output logic              res_bad,
    output logic              frame_err,
    output logic              busy
);

    localparam int WORDS = N_IN / PIX_PER_WORD;
    localparam int WC_W  = cnt_width(WORDS);
    localparam logic [WC_W-1:0] c_last_word = WC_W'(WORDS - 1);
    localparam logic [4:0]      c_n_out     = 5'(N_OUT);

    state_t          r_state;
    logic [WC_W-1:0] r_word_cnt;
    logic            r_tlast;
    logic            r_frame_err;
    logic [3:0]      r_res_class;
    logic            r_res_bad;

    logic w_tready;
    logic w_accept;
    logic w_is_last_word;
    logic w_early_end;
    logic w_load;
    logic w_step;
    logic w_last_lane;

    // Handshake decode; an early tlast drops the word instead of loading it
    always_comb begin
        w_tready       = (r_state == S_RECV) || (r_state == S_DRAIN);
        w_accept       = s_axis_tvalid && w_tready;
        w_is_last_word = (r_word_cnt == c_last_word);
        w_early_end    = s_axis_tlast && !w_is_last_word;
        w_load         = (r_state == S_RECV) && w_accept && !w_early_end;
        w_step         = (r_state == S_UNPACK);
    end

    word_unpacker #(
        .ADDR_W (ADDR_W),
        .WC_W   (WC_W)
    ) u_unpacker (
        .clk         (clk),
        .rst         (rst),
        .i_load      (w_load),
        .i_step      (w_step),
        .i_word      (s_axis_tdata),
        .i_word_cnt  (r_word_cnt),
        .o_last_lane (w_last_lane),
        .o_pix_we    (pix_we),
        .o_pix_addr  (pix_addr),
        .o_pix_data  (pix_data)
    );

    // Frame sequencing: receive, unpack, optional drain, inference, result, re-arm
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_RECV;
            r_word_cnt  <= '0;
            r_tlast     <= 1'b0;
            r_frame_err <= 1'b0;
            r_res_class <= '0;
            r_res_bad   <= 1'b0;
        end else begin
            case (r_state)
                S_RECV: begin
                    if (w_accept) begin
                        if (w_early_end) begin
                            r_frame_err <= 1'b1;
                            r_word_cnt  <= '0;
                        end else begin
                            r_tlast <= s_axis_tlast;
                            r_state <= S_UNPACK;
                        end
                    end
                end
                S_UNPACK: begin
                    if (w_last_lane) begin
                        if (!w_is_last_word) begin
                            r_word_cnt <= r_word_cnt + WC_W'(1);
                            r_state    <= S_RECV;
                        end else if (r_tlast) begin
                            r_state <= S_START;
                        end else begin
                            // Image is complete; discard the overrun up to tlast
                            r_frame_err <= 1'b1;
                            r_state     <= S_DRAIN;
                        end
                    end
                end
                S_DRAIN: begin
                    if (w_accept && s_axis_tlast) begin
                        r_state <= S_START;
                    end
                end
                S_START: begin
                    if (core_done) begin
                        r_res_class <= core_predicted;
                        r_res_bad   <= ({1'b0, core_predicted} >= c_n_out);
                        r_state     <= S_RESULT;
                    end
                end
                S_RESULT: begin
                    if (res_ready) begin
                        r_state <= S_REARM;
                    end
                end
                S_REARM: begin
                    // Core must be idle again before the next frame's pixels land
                    if (!core_done) begin
                        r_word_cnt <= '0;
                        r_state    <= S_RECV;
                    end
                end
                default: begin
                    r_state <= S_RECV;
                end
            endcase
        end
    end

    assign s_axis_tready = w_tready;
    assign core_start    = (r_state == S_START);
    assign res_valid     = (r_state == S_RESULT);
    assign res_class     = r_res_class;
    assign res_bad       = r_res_bad;
    assign frame_err     = r_frame_err;
    assign busy          = (r_state != S_RECV);

endmodule
`default_nettype wire
